// File: rtl/combin_arb_pkg.sv
// Shared types and helpers for the combiner stream arbiter: FSM states,
// width derivation and the round-robin search.
package combin_arb_pkg;

  localparam int MAX_REQ = 16;

  typedef enum logic [1:0] {IDLE, GRANT, PAD} state_t;

  // Index width that never collapses to zero bits for single-entry ranges.
  function automatic int width_of(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // First set bit of req searching upward from ptr+1 with wrap over n entries.
  function automatic logic [3:0] rr_pick(input logic [MAX_REQ-1:0] req,
                                         input logic [3:0] ptr,
                                         input int n);
    logic [3:0] win;
    logic [3:0] idx;
    logic       found;
    win   = '0;
    found = 1'b0;
    for (int k = 1; k <= MAX_REQ; k++) begin
      idx = 4'((int'(ptr) + k) % n);
      if (k <= n && !found && req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/combin_stream_arb_rr_arbiter.sv
// Round-robin pick: combinational winner from the request vector and a
// registered last-winner pointer that advances only when load is asserted.
module rr_arbiter
  import combin_arb_pkg::*;
#(
  parameter  int NREQ = 4,
  localparam int IW   = width_of(NREQ)
) (
  input  logic            clock,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  input  logic            load,
  output logic [IW-1:0]   winner,
  output logic            any
);

  logic [IW-1:0] ptr;
  logic [3:0]    pick;

  assign pick   = rr_pick(MAX_REQ'(req), 4'(ptr), NREQ);
  assign winner = IW'(pick);
  assign any    = |req;

  // Pointer starts at the top entry so entry 0 is preferred after reset.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= IW'(NREQ - 1);
    end else if (load) begin
      ptr <= winner;
    end
  end

endmodule

// File: rtl/combin_stream_arb.sv
// Packet-atomic round-robin arbiter feeding one width combiner; pads short
// packet tails with PAD_VAL beats so every packet ends on a word boundary.
module combin_stream_arb
  import combin_arb_pkg::*;
#(
  parameter  int               DSIZE   = 1,
  parameter  int               NSIZE   = 8,
  parameter  int               NREQ    = 4,
  parameter  logic [DSIZE-1:0] PAD_VAL = '0,
  localparam int               IW      = width_of(NREQ),
  localparam int               CW      = width_of(NSIZE)
) (
  input  logic                  clock,
  input  logic                  rst_n,
  input  logic [NREQ*DSIZE-1:0] req_data,
  input  logic [NREQ-1:0]       req_vld,
  input  logic [NREQ-1:0]       req_last,
  output logic [NREQ-1:0]       req_ready,
  output logic [DSIZE-1:0]      cmb_wr_data,
  output logic                  cmb_wr_vld,
  output logic                  cmb_wr_last,
  output logic                  cmb_wr_align_last,
  input  logic                  cmb_wr_ready,
  output logic [IW-1:0]         gnt_id,
  output logic                  busy,
  output logic                  pkt_done
);

  localparam logic [CW-1:0] LAST_CNT = CW'(NSIZE - 1);

  state_t            state;
  logic [CW-1:0]     beat_cnt;
  logic [IW-1:0]     winner;
  logic              any;
  logic              sel_vld;
  logic              sel_last;
  logic [DSIZE-1:0]  sel_data;
  logic [NREQ-1:0]   gnt_onehot;
  logic              at_end;
  logic              accept;

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .clock  (clock),
    .rst_n  (rst_n),
    .req    (req_vld),
    .load   (state == IDLE && any),
    .winner (winner),
    .any    (any)
  );

  always_comb begin
    sel_vld    = 1'b0;
    sel_last   = 1'b0;
    sel_data   = '0;
    gnt_onehot = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_id == IW'(i)) begin
        sel_vld       = req_vld[i];
        sel_last      = req_last[i];
        sel_data      = req_data[i*DSIZE +: DSIZE];
        gnt_onehot[i] = 1'b1;
      end
    end
  end

  assign at_end = (beat_cnt == LAST_CNT);

  // Outputs decode straight from the state register, so reset clears them at once.
  always_comb begin
    cmb_wr_vld  = 1'b0;
    cmb_wr_data = '0;
    cmb_wr_last = 1'b0;
    req_ready   = '0;
    unique case (state)
      GRANT: begin
        cmb_wr_vld  = sel_vld;
        cmb_wr_data = sel_data;
        cmb_wr_last = sel_last & at_end;
        req_ready   = cmb_wr_ready ? gnt_onehot : '0;
      end
      PAD: begin
        cmb_wr_vld  = 1'b1;
        cmb_wr_data = PAD_VAL;
        cmb_wr_last = at_end;
      end
      default: ;
    endcase
  end

  assign cmb_wr_align_last = cmb_wr_last;
  assign accept            = cmb_wr_vld & cmb_wr_ready;
  assign busy              = (state != IDLE);

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      beat_cnt <= '0;
      gnt_id   <= '0;
      pkt_done <= 1'b0;
    end else begin
      pkt_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (any) begin
            gnt_id <= winner;
            state  <= GRANT;
          end
        end
        GRANT: begin
          if (accept) begin
            if (sel_last && at_end) begin
              beat_cnt <= '0;
              state    <= IDLE;
              pkt_done <= 1'b1;
            end else if (sel_last) begin
              beat_cnt <= beat_cnt + CW'(1);
              state    <= PAD;
            end else begin
              beat_cnt <= at_end ? '0 : beat_cnt + CW'(1);
            end
          end
        end
        PAD: begin
          if (accept) begin
            if (at_end) begin
              beat_cnt <= '0;
              state    <= IDLE;
              pkt_done <= 1'b1;
            end else begin
              beat_cnt <= beat_cnt + CW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_combin_stream_arb.sv
// Directed bench for combin_stream_arb with a bench-side requester driver and
// an MSB-first word assembly model standing in for the combiner.
module tb_combin_stream_arb;

  logic       clock = 1'b0;
  logic       rst_n;
  logic [3:0] req_data, req_vld, req_last, req_ready;
  logic       cmb_wr_data, cmb_wr_vld, cmb_wr_last, cmb_wr_align_last, cmb_wr_ready;
  logic [1:0] gnt_id;
  logic       busy, pkt_done;

  always #5 clock = ~clock;

  combin_stream_arb #(.DSIZE(1), .NSIZE(8), .NREQ(4), .PAD_VAL(1'b0)) dut (
    .clock(clock), .rst_n(rst_n),
    .req_data(req_data), .req_vld(req_vld), .req_last(req_last), .req_ready(req_ready),
    .cmb_wr_data(cmb_wr_data), .cmb_wr_vld(cmb_wr_vld), .cmb_wr_last(cmb_wr_last),
    .cmb_wr_align_last(cmb_wr_align_last), .cmb_wr_ready(cmb_wr_ready),
    .gnt_id(gnt_id), .busy(busy), .pkt_done(pkt_done)
  );

  typedef struct {
    logic       d;
    logic       l;
    logic [1:0] g;
    logic       is_real;
    int         c;
  } beat_t;

  int         n_checks = 0;
  int         n_errors = 0;
  logic       q_dat[4][$];
  logic       q_last[4][$];
  logic [3:0] hold;
  bit         rdy_toggle;
  beat_t      acc[$];
  logic [7:0] words[$];
  logic       wlast[$];
  logic       busy_log[$];
  logic [7:0] word_sr;
  int         nb;
  bit         model_pad, pd_pending;
  int         cyc, last_err, pd_err, align_err, pad_err, pd_cnt;

  // Packet analysis results filled by analyse().
  int         order[$];
  int         start_cyc[$];
  int         end_cyc[$];
  int         pad_beats, real_beats, gnt_changes;

  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      if (q_dat[i].size() > 0 && !hold[i]) begin
        req_vld[i]  = 1'b1;
        req_data[i] = q_dat[i][0];
        req_last[i] = q_last[i][0];
      end else begin
        req_vld[i]  = 1'b0;
        req_data[i] = 1'b0;
        req_last[i] = 1'b0;
      end
    end
  endtask

  task automatic load(input int r, input logic [15:0] bits, input int n);
    for (int k = 0; k < n; k++) begin
      q_dat[r].push_back(bits[n-1-k]);
      q_last[r].push_back(k == n - 1);
    end
    drive();
  endtask

  task automatic clear_logs();
    acc.delete(); words.delete(); wlast.delete(); busy_log.delete();
    cyc = 0; last_err = 0; pd_err = 0; align_err = 0; pad_err = 0; pd_cnt = 0;
  endtask

  function automatic bit queues_empty();
    return q_dat[0].size() == 0 && q_dat[1].size() == 0 &&
           q_dat[2].size() == 0 && q_dat[3].size() == 0;
  endfunction

  // One clock: observe at negedge, then update requester drives after posedge.
  task automatic step();
    logic [3:0] hs;
    logic       accept_now, rl, exp_last;
    beat_t      b;
    @(negedge clock);
    hs         = req_vld & req_ready;
    accept_now = cmb_wr_vld && cmb_wr_ready;
    if (cmb_wr_align_last !== cmb_wr_last) align_err++;
    if (pkt_done !== pd_pending) pd_err++;
    if (pkt_done === 1'b1) pd_cnt++;
    pd_pending = 1'b0;
    if (model_pad && (cmb_wr_vld !== 1'b1 || req_ready !== 4'b0 || cmb_wr_data !== 1'b0))
      pad_err++;
    busy_log.push_back(busy);
    if (accept_now) begin
      rl = 1'b0;
      for (int i = 0; i < 4; i++) if (hs[i]) rl = req_last[i];
      word_sr  = {word_sr[6:0], cmb_wr_data};
      nb++;
      exp_last = (nb == 8) && (model_pad || rl);
      if (cmb_wr_last !== exp_last) last_err++;
      b.d = cmb_wr_data; b.l = cmb_wr_last; b.g = gnt_id; b.is_real = |hs; b.c = cyc;
      acc.push_back(b);
      if (nb == 8) begin
        words.push_back(word_sr);
        wlast.push_back(cmb_wr_last);
        nb = 0;
        if (exp_last) begin
          pd_pending = 1'b1;
          model_pad  = 1'b0;
        end
      end else if (rl) begin
        model_pad = 1'b1;
      end
    end
    cyc++;
    @(posedge clock);
    #1;
    for (int i = 0; i < 4; i++) begin
      if (hs[i]) begin
        void'(q_dat[i].pop_front());
        void'(q_last[i].pop_front());
      end
    end
    drive();
    cmb_wr_ready = rdy_toggle ? ~cmb_wr_ready : 1'b1;
  endtask

  task automatic run_until_idle(input int max_cyc, output bit timed_out);
    timed_out = 1'b1;
    for (int k = 0; k < max_cyc; k++) begin
      step();
      if (queues_empty() && busy === 1'b0 && !pd_pending && !model_pad) begin
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  task automatic analyse();
    bit         new_pkt;
    logic [1:0] prev_g;
    bit         have_prev;
    order.delete(); start_cyc.delete(); end_cyc.delete();
    pad_beats = 0; real_beats = 0; gnt_changes = 0;
    new_pkt = 1'b1; have_prev = 1'b0; prev_g = 2'd0;
    foreach (acc[k]) begin
      if (acc[k].is_real) begin
        real_beats++;
        if (have_prev && acc[k].g != prev_g) gnt_changes++;
        prev_g = acc[k].g; have_prev = 1'b1;
        if (new_pkt) begin
          order.push_back(int'(acc[k].g));
          start_cyc.push_back(acc[k].c);
          new_pkt = 1'b0;
        end
      end else begin
        pad_beats++;
      end
      if (acc[k].l) begin
        end_cyc.push_back(acc[k].c);
        new_pkt = 1'b1;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cmb_wr_ready = 1'b1; rdy_toggle = 1'b0; hold = 4'b0;
    word_sr = 8'h00; nb = 0; model_pad = 1'b0; pd_pending = 1'b0;
    req_vld = 4'hF; req_last = 4'hF; req_data = 4'hF;
    #12;
    n_checks++; if (cmb_wr_vld !== 1'b0) begin n_errors++; $display("FAIL reset_wr_vld: got %b want 0", cmb_wr_vld); end
    n_checks++; if (req_ready !== 4'b0) begin n_errors++; $display("FAIL reset_req_ready: got %b want 0000", req_ready); end
    n_checks++; if (cmb_wr_last !== 1'b0) begin n_errors++; $display("FAIL reset_wr_last: got %b want 0", cmb_wr_last); end
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (gnt_id !== 2'd0) begin n_errors++; $display("FAIL reset_gnt_id: got %0d want 0", gnt_id); end
    n_checks++; if (pkt_done !== 1'b0) begin n_errors++; $display("FAIL reset_pkt_done: got %b want 0", pkt_done); end
    drive();
    @(posedge clock); #1;
    rst_n = 1'b1;
    clear_logs();
  endtask

  task automatic test_single_full();
    bit to;
    clear_logs();
    load(1, 16'h00B2, 8);
    run_until_idle(60, to);
    analyse();
    n_checks++; if (to !== 1'b0) begin n_errors++; $display("FAIL single_timeout: got %b want 0", to); end
    n_checks++; if (words.size() !== 1 || words[0] !== 8'hB2) begin n_errors++; $display("FAIL single_word: got %0d words first %h want 1 word b2", words.size(), words[0]); end
    n_checks++; if (wlast[0] !== 1'b1) begin n_errors++; $display("FAIL single_rd_last: got %b want 1", wlast[0]); end
    n_checks++; if (pad_beats !== 0) begin n_errors++; $display("FAIL single_pad: got %0d want 0", pad_beats); end
    n_checks++; if (pd_cnt !== 1) begin n_errors++; $display("FAIL single_pkt_done_count: got %0d want 1", pd_cnt); end
    n_checks++; if (gnt_id !== 2'd1) begin n_errors++; $display("FAIL single_gnt_id: got %0d want 1", gnt_id); end
    n_checks++; if (last_err + pd_err + align_err !== 0) begin n_errors++; $display("FAIL single_protocol: last %0d done %0d align %0d want 0", last_err, pd_err, align_err); end
  endtask

  task automatic test_short_pad();
    bit to;
    clear_logs();
    load(2, 16'h0007, 3);
    run_until_idle(60, to);
    analyse();
    n_checks++; if (to !== 1'b0) begin n_errors++; $display("FAIL short_timeout: got %b want 0", to); end
    n_checks++; if (words.size() !== 1 || words[0] !== 8'hE0) begin n_errors++; $display("FAIL short_word: got %0d words first %h want 1 word e0", words.size(), words[0]); end
    n_checks++; if (pad_beats !== 5) begin n_errors++; $display("FAIL short_pad_beats: got %0d want 5", pad_beats); end
    n_checks++; if (end_cyc.size() !== 1 || acc[7].l !== 1'b1) begin n_errors++; $display("FAIL short_last_position: got %0d lasts want 1 on beat 8", end_cyc.size()); end
    n_checks++; if (pad_err !== 0) begin n_errors++; $display("FAIL short_pad_outputs: got %0d bad cycles want 0", pad_err); end
    n_checks++; if (last_err + pd_err + align_err !== 0) begin n_errors++; $display("FAIL short_protocol: last %0d done %0d align %0d want 0", last_err, pd_err, align_err); end
  endtask

  task automatic test_arb_order();
    bit         to;
    logic [7:0] exp_w[6];
    exp_w = '{8'hA5, 8'h3C, 8'h0F, 8'hF0, 8'h81, 8'h7E};
    @(posedge clock); #1;
    rst_n = 1'b0;
    load(0, 16'hA53C, 16);
    load(2, 16'h0FF0, 16);
    load(3, 16'h817E, 16);
    @(posedge clock); #1;
    rst_n = 1'b1;
    clear_logs();
    run_until_idle(200, to);
    analyse();
    n_checks++; if (to !== 1'b0) begin n_errors++; $display("FAIL order_timeout: got %b want 0", to); end
    n_checks++; if (order.size() !== 3) begin n_errors++; $display("FAIL order_count: got %0d want 3", order.size()); end
    n_checks++; if (order[0] !== 0 || order[1] !== 2 || order[2] !== 3) begin n_errors++; $display("FAIL order_sequence: got %0d,%0d,%0d want 0,2,3", order[0], order[1], order[2]); end
    n_checks++; if (gnt_changes !== 2) begin n_errors++; $display("FAIL order_interleave: got %0d grant changes want 2", gnt_changes); end
    for (int k = 0; k < 2; k++) begin
      n_checks++; if (start_cyc[k+1] - end_cyc[k] !== 2) begin n_errors++; $display("FAIL order_gap%0d: got %0d cycles want 2", k, start_cyc[k+1] - end_cyc[k]); end
      n_checks++; if (busy_log[end_cyc[k]+1] !== 1'b0) begin n_errors++; $display("FAIL order_bubble%0d: busy got %b want 0", k, busy_log[end_cyc[k]+1]); end
    end
    for (int k = 0; k < 6; k++) begin
      n_checks++; if (words[k] !== exp_w[k] || wlast[k] !== logic'(k % 2)) begin n_errors++; $display("FAIL order_word%0d: got %h last %b want %h last %0d", k, words[k], wlast[k], exp_w[k], k % 2); end
    end
    n_checks++; if (last_err + pd_err + align_err !== 0) begin n_errors++; $display("FAIL order_protocol: last %0d done %0d align %0d want 0", last_err, pd_err, align_err); end
  endtask

  task automatic test_backpressure();
    bit to;
    clear_logs();
    rdy_toggle = 1'b1;
    load(0, 16'h1876, 13);
    run_until_idle(120, to);
    rdy_toggle = 1'b0;
    cmb_wr_ready = 1'b1;
    analyse();
    n_checks++; if (to !== 1'b0) begin n_errors++; $display("FAIL bp_timeout: got %b want 0", to); end
    n_checks++; if (acc.size() !== 16) begin n_errors++; $display("FAIL bp_accepted: got %0d want 16", acc.size()); end
    n_checks++; if (real_beats !== 13 || pad_beats !== 3) begin n_errors++; $display("FAIL bp_split: got %0d real %0d pad want 13 real 3 pad", real_beats, pad_beats); end
    n_checks++; if (words.size() !== 2 || words[0] !== 8'hC3 || words[1] !== 8'hB0) begin n_errors++; $display("FAIL bp_words: got %0d words %h %h want c3 b0", words.size(), words[0], words[1]); end
    n_checks++; if (pad_err !== 0) begin n_errors++; $display("FAIL bp_pad_valid: got %0d bad cycles want 0", pad_err); end
    n_checks++; if (last_err + pd_err + align_err !== 0) begin n_errors++; $display("FAIL bp_protocol: last %0d done %0d align %0d want 0", last_err, pd_err, align_err); end
  endtask

  task automatic test_hold_grant();
    bit to;
    clear_logs();
    load(1, 16'h005A, 8);
    load(3, 16'h0096, 8);
    for (int k = 0; k < 40 && acc.size() < 3; k++) step();
    hold[1] = 1'b1;
    drive();
    for (int k = 0; k < 5; k++) step();
    n_checks++; if (acc.size() !== 3) begin n_errors++; $display("FAIL hold_no_beats: got %0d accepted want 3", acc.size()); end
    n_checks++; if (gnt_id !== 2'd1 || busy !== 1'b1) begin n_errors++; $display("FAIL hold_grant_kept: got gnt %0d busy %b want gnt 1 busy 1", gnt_id, busy); end
    hold[1] = 1'b0;
    drive();
    run_until_idle(100, to);
    analyse();
    n_checks++; if (to !== 1'b0) begin n_errors++; $display("FAIL hold_timeout: got %b want 0", to); end
    n_checks++; if (order.size() !== 2 || order[0] !== 1 || order[1] !== 3 || gnt_changes !== 1) begin n_errors++; $display("FAIL hold_order: got %0d pkts first %0d changes %0d want 1 then 3", order.size(), order[0], gnt_changes); end
    n_checks++; if (words.size() !== 2 || words[0] !== 8'h5A || words[1] !== 8'h96) begin n_errors++; $display("FAIL hold_words: got %h %h want 5a 96", words[0], words[1]); end
  endtask

  task automatic test_reset_mid_pad();
    bit to;
    clear_logs();
    load(2, 16'h0001, 1);
    for (int k = 0; k < 40 && !(model_pad && acc.size() >= 3); k++) step();
    n_checks++; if (model_pad !== 1'b1) begin n_errors++; $display("FAIL midpad_reached: got %b want 1", model_pad); end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if (cmb_wr_vld !== 1'b0) begin n_errors++; $display("FAIL midpad_async_vld: got %b want 0", cmb_wr_vld); end
    n_checks++; if (busy !== 1'b0 || req_ready !== 4'b0) begin n_errors++; $display("FAIL midpad_async_state: busy %b ready %b want 0 0000", busy, req_ready); end
    for (int i = 0; i < 4; i++) begin q_dat[i].delete(); q_last[i].delete(); end
    model_pad = 1'b0; nb = 0; word_sr = 8'h00; pd_pending = 1'b0;
    drive();
    @(posedge clock); #1;
    @(posedge clock); #1;
    rst_n = 1'b1;
    clear_logs();
    for (int k = 0; k < 4; k++) step();
    n_checks++; if (acc.size() !== 0) begin n_errors++; $display("FAIL midpad_no_pad_after: got %0d beats want 0", acc.size()); end
    load(3, 16'h00C5, 8);
    load(0, 16'h003C, 8);
    run_until_idle(100, to);
    analyse();
    n_checks++; if (to !== 1'b0) begin n_errors++; $display("FAIL midpad_timeout: got %b want 0", to); end
    n_checks++; if (order[0] !== 0) begin n_errors++; $display("FAIL midpad_first_grant: got %0d want 0", order[0]); end
    n_checks++; if (words.size() !== 2 || words[0] !== 8'h3C || words[1] !== 8'hC5 || pad_beats !== 0) begin n_errors++; $display("FAIL midpad_words: got %0d words %h %h pads %0d want 3c c5 no pads", words.size(), words[0], words[1], pad_beats); end
    n_checks++; if (last_err + pd_err + align_err !== 0) begin n_errors++; $display("FAIL midpad_protocol: last %0d done %0d align %0d want 0", last_err, pd_err, align_err); end
  endtask

  initial begin
    test_reset();
    test_single_full();
    test_short_pad();
    test_arb_order();
    test_backpressure();
    test_hold_grant();
    test_reset_mid_pad();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/combin_stream_arb.md
Name: combin_stream_arb

Overview:
- Packet-atomic round-robin arbiter that shares one width_combin instance among NREQ serial requesters.
- Forwards each requester's DSIZE-bit beat stream with valid/ready/last, holding the grant until the packet's last beat.
- Pads short packet tails with PAD_VAL beats so every packet ends on an NSIZE-beat word boundary. The combiner therefore always emits a complete final word carrying rd_last.
- Sits between the per-source serializers and the combiner's write port.

Parameters:
- DSIZE, 1, beat width; must match the combiner's DSIZE.
- NSIZE, 8, beats per combined word; must match the combiner's NSIZE; range 1..255.
- NREQ, 4, number of requesters; range 1..16.
- PAD_VAL, 0, DSIZE-bit value driven on inserted pad beats.
- Derived: IW = max(1, clog2(NREQ)); CW = max(1, clog2(NSIZE)).

Ports:
- clock  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- req_data  in  NREQ*DSIZE  per-requester beat; requester i occupies bits [DSIZE*(i+1)-1 : DSIZE*i]
- req_vld  in  NREQ  per-requester beat valid
- req_last  in  NREQ  per-requester last beat of packet
- req_ready  out  NREQ  per-requester beat accepted when vld&ready
- cmb_wr_data  out  DSIZE  to combiner wr_data
- cmb_wr_vld  out  1  to combiner wr_vld
- cmb_wr_last  out  1  to combiner wr_last
- cmb_wr_align_last  out  1  to combiner wr_align_last
- cmb_wr_ready  in  1  from combiner wr_ready
- gnt_id  out  IW  currently or most recently granted requester
- busy  out  1  high in GRANT or PAD
- pkt_done  out  1  one-cycle pulse after the final beat (real or pad) is accepted

Behaviour:
- Reset (async, rst_n=0): state=IDLE, beat_cnt=0, gnt_id=0, rr_ptr=NREQ-1 (requester 0 wins first), pkt_done=0.
- Reset forces all req_ready and cmb_wr_* outputs to 0 immediately.
- Reset mid-packet abandons the packet; no pad beats are issued afterwards.
- Beat acceptance: accept = cmb_wr_vld & cmb_wr_ready.
- IDLE:
  - cmb_wr_vld=0; req_ready=0.
  - If any req_vld, grant the first set bit searching from (rr_ptr+1) mod NREQ upward, with wrap-around.
  - Register gnt_id and rr_ptr from the winner; go to GRANT next cycle.
  - Arbitration latency is 1 cycle; there is one bubble cycle between packets.
- GRANT:
  - Pass-through is combinational: cmb_wr_data=req_data[gnt_id], cmb_wr_vld=req_vld[gnt_id], req_ready[gnt_id]=cmb_wr_ready; all other req_ready=0.
  - Grant is held while req_vld[gnt_id]=0; packets are never cut.
  - On accept with req_last[gnt_id]=0: beat_cnt wraps at NSIZE-1 to 0, otherwise increments.
  - On accept with req_last=1 and beat_cnt==NSIZE-1: cmb_wr_last=1 on that beat; beat_cnt<=0; go to IDLE; pkt_done pulses.
  - On accept with req_last=1 and beat_cnt<NSIZE-1: cmb_wr_last=0 on that beat; beat_cnt++; go to PAD.
- PAD:
  - cmb_wr_vld=1; cmb_wr_data=PAD_VAL; all req_ready=0.
  - On each accept beat_cnt++.
  - The beat issued at beat_cnt==NSIZE-1 carries cmb_wr_last=1; when it is accepted: beat_cnt<=0, go to IDLE, pkt_done pulses.
- cmb_wr_align_last equals cmb_wr_last at all times.
- Valid stability: cmb_wr_vld in PAD is never withdrawn before acceptance.
- Stall: cmb_wr_ready=0 holds state, beat_cnt and outputs (pass-through mirrors the granted requester).
- NSIZE=1: beat_cnt stays 0; every last beat goes straight to IDLE; PAD is unreachable.
- NREQ=1: rr search is trivial; gnt_id stays 0.
- A requester asserting req_last on its first beat is legal; it yields NSIZE-1 pad beats.
- busy=1 in GRANT and PAD, 0 in IDLE; gnt_id keeps its value in IDLE.

Decomposition:
- Package combin_arb_pkg: state enum {IDLE, GRANT, PAD}; function rr_pick(req, ptr) returning the winner index; helper for IW/CW width computation.
- One sub-module, rr_arbiter: combinational round-robin pick (req vector, ptr -> winner, any) plus registered pointer. It is reusable elsewhere.
- Top-level holds the FSM, beat counter and mux.

Test Plan:
- Single packet, requester 1 (NREQ=4, NSIZE=8, DSIZE=1), 8 beats 1,0,1,1,0,0,1,0 with last on beat 8 -> no pad; cmb_wr_last on beat 8; combiner rd_data=8'hB2 with rd_last=1; pkt_done one pulse; gnt_id=1.
- Short packet of 3 beats 1,1,1 with PAD_VAL=0 -> 5 pad beats follow the real last; cmb_wr_last only on the 8th beat; combiner word 8'hE0 with rd_last=1; req_ready=0 during PAD.
- Requesters 0, 2 and 3 all valid at reset exit with 2-word packets -> grant order 0,2,3; no interleaving; exactly one IDLE bubble cycle between packets.
- Back-pressure: toggle cmb_wr_ready every other cycle during GRANT and PAD -> no beat lost or duplicated; 16 accepted beats produce 2 words; cmb_wr_vld never drops while in PAD.
- Requester drops req_vld for 5 cycles mid-packet while requester 3 is valid -> grant stays on the original requester; packet completes before requester 3 is granted.
- Assert rst_n=0 asynchronously mid-PAD -> cmb_wr_vld=0 before the next clock edge; after release state=IDLE and the next grant goes to requester 0.
